// File: rtl/ntt_coeff_buffer_if.sv
// Bus bundle between ntt_coeff_buffer and its neighbours: input stream, the
// memory-wrapper read/write ports and the result stream.
interface ntt_coeff_buffer_if #(
    parameter int LOGQ = 64,
    parameter int LOGN = 4
) ();
    localparam int ADDRW = ((LOGN < 9) ? 9 : LOGN) + 1;

    logic             s_valid;
    logic             s_ready;
    logic [LOGQ-1:0]  s_data;
    logic             ntt_start;
    logic             ntt_finish;
    logic [ADDRW-1:0] ntt_read_address;
    logic [LOGQ-1:0]  ntt_data_in_0;
    logic [LOGQ-1:0]  ntt_data_in_1;
    logic [ADDRW-1:0] ntt_write_address;
    logic             ntt_wea;
    logic [LOGQ-1:0]  ntt_data_out_0;
    logic [LOGQ-1:0]  ntt_data_out_1;
    logic             m_valid;
    logic             m_ready;
    logic [LOGQ-1:0]  m_data;

    modport slave (
        input  s_valid, s_data, ntt_finish, ntt_read_address, ntt_write_address,
               ntt_wea, ntt_data_out_0, ntt_data_out_1, m_ready,
        output s_ready, ntt_start, ntt_data_in_0, ntt_data_in_1, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, ntt_finish, ntt_read_address, ntt_write_address,
               ntt_wea, ntt_data_out_0, ntt_data_out_1, m_ready,
        input  s_ready, ntt_start, ntt_data_in_0, ntt_data_in_1, m_valid, m_data
    );
endinterface

// File: rtl/ntt_coeff_buffer.sv
// Coefficient staging buffer around the NTT memory wrapper: load, run, drain.
// Optional address-range checking is built when NTT_BUF_ADDR_CHECK_EN is defined.
module ntt_coeff_buffer #(
    parameter int LOGQ       = 64,
    parameter int LOGN       = 4,
    parameter int DELAY_BRAM = 1
) (
    input  logic clk,
    input  logic rst,
    ntt_coeff_buffer_if.slave bus,
    output logic busy,
    output logic addr_err
);
    localparam int N     = 1 << LOGN;
    localparam int HW    = LOGN - 1;
    localparam int ADDRW = ((LOGN < 9) ? 9 : LOGN) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
    state_t state, state_n;

    logic [LOGQ-1:0] din  [N];
    logic [LOGQ-1:0] dout [N];

    logic [LOGN-1:0] cnt, rd_cnt, out_cnt;
    logic            rd_done;
    logic            s_fire, m_fire, issue;
    logic [HW-1:0]   ra, wa;

    assign ra     = bus.ntt_read_address[HW-1:0];
    assign wa     = bus.ntt_write_address[HW-1:0];
    assign s_fire = bus.s_valid && bus.s_ready;
    assign m_fire = bus.m_valid && bus.m_ready;

    assign bus.s_ready = (state == IDLE) || (state == LOAD);
    assign busy        = (state != IDLE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (s_fire) state_n = LOAD;
            LOAD:    if (s_fire && cnt == LOGN'(N-1)) state_n = RUN;
            RUN:     if (bus.ntt_finish) state_n = DRAIN;
            DRAIN:   if (m_fire && out_cnt == LOGN'(N-1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.ntt_start <= 1'b0;
        end else begin
            state         <= state_n;
            bus.ntt_start <= (state_n == RUN);
            if (s_fire) cnt <= cnt + 1'b1;
        end
    end

    // Storage has no reset; contents survive rst by design.
    always_ff @(posedge clk) begin
        if (!rst && s_fire) din[cnt] <= bus.s_data;
        if (!rst && state == RUN && bus.ntt_wea) begin
            dout[{1'b0, wa}] <= bus.ntt_data_out_0;
            dout[{1'b1, wa}] <= bus.ntt_data_out_1;
        end
    end

    logic [DELAY_BRAM-1:0][LOGQ-1:0] rp0, rp1;
    always_ff @(posedge clk) begin
        if (rst) begin
            rp0 <= '0;
            rp1 <= '0;
        end else begin
            rp0[0] <= din[{1'b0, ra}];
            rp1[0] <= din[{1'b1, ra}];
            for (int i = 1; i < DELAY_BRAM; i++) begin
                rp0[i] <= rp0[i-1];
                rp1[i] <= rp1[i-1];
            end
        end
    end
    assign bus.ntt_data_in_0 = rp0[DELAY_BRAM-1];
    assign bus.ntt_data_in_1 = rp1[DELAY_BRAM-1];

    // Drain pipe: read reg -> output reg, with a skid reg catching the word
    // already in flight when the consumer stalls. Only issue a read if the
    // word will have a landing slot even with no pop next cycle.
    logic            r_vld, skid_vld;
    logic [LOGQ-1:0] r_data, skid_data;
    logic [1:0]      occ_after;

    assign occ_after = 2'(r_vld) + 2'(bus.m_valid) + 2'(skid_vld) - 2'(m_fire);
    assign issue     = (state == DRAIN) && !rd_done && (occ_after <= 2'd1);

    always_ff @(posedge clk) begin
        if (issue) r_data <= dout[rd_cnt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt      <= '0;
            rd_done     <= 1'b0;
            out_cnt     <= '0;
            r_vld       <= 1'b0;
            skid_vld    <= 1'b0;
            skid_data   <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
        end else begin
            r_vld <= issue;
            if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == LOGN'(N-1)) rd_done <= 1'b1;
            end
            if (state != DRAIN) rd_done <= 1'b0;
            if (m_fire) out_cnt <= out_cnt + 1'b1;

            if (m_fire || !bus.m_valid) begin
                if (skid_vld) begin
                    bus.m_data  <= skid_data;
                    bus.m_valid <= 1'b1;
                    skid_vld    <= r_vld;
                    if (r_vld) skid_data <= r_data;
                end else if (r_vld) begin
                    bus.m_data  <= r_data;
                    bus.m_valid <= 1'b1;
                end else begin
                    bus.m_valid <= 1'b0;
                end
            end else if (r_vld) begin
                skid_vld  <= 1'b1;
                skid_data <= r_data;
            end
        end
    end

`ifdef NTT_BUF_ADDR_CHECK_EN
    logic rd_bad, wr_bad;
    assign rd_bad = |bus.ntt_read_address[ADDRW-1:HW];
    assign wr_bad = |bus.ntt_write_address[ADDRW-1:HW];

    always_ff @(posedge clk) begin
        if (rst)
            addr_err <= 1'b0;
        else if (state == IDLE && s_fire)
            addr_err <= 1'b0;
        else if (state == RUN && (rd_bad || (bus.ntt_wea && wr_bad)))
            addr_err <= 1'b1;
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.ntt_read_address[ADDRW-1:HW],
                              bus.ntt_write_address[ADDRW-1:HW]};
    assign addr_err = 1'b0;
`endif
endmodule

// File: tb/tb_ntt_coeff_buffer.sv
// Scoreboard bench for ntt_coeff_buffer: load, paired reads, paired writes
// with finish, drain with and without back-pressure, mid-run reset.
module tb_ntt_coeff_buffer;
    localparam int LOGQ = 64, LOGN = 4, N = 16, H = 8, DELAY_BRAM = 1;
`ifdef NTT_BUF_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, addr_err;
    int   vectors = 0;
    int   errors  = 0;

    logic [LOGQ-1:0] din_m  [N];
    logic [LOGQ-1:0] dout_m [N];
    logic [LOGQ-1:0] exp_q  [$];

    ntt_coeff_buffer_if #(.LOGQ(LOGQ), .LOGN(LOGN)) bif ();

    ntt_coeff_buffer #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(DELAY_BRAM)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif),
        .busy     (busy),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.s_valid = 1'b0; bif.s_data = '0; bif.ntt_finish = 1'b0;
        bif.ntt_read_address = '0; bif.ntt_write_address = '0; bif.ntt_wea = 1'b0;
        bif.ntt_data_out_0 = '0; bif.ntt_data_out_1 = '0; bif.m_ready = 1'b0;
        step(); step();
        vectors++;
        if ({bif.ntt_start, bif.m_valid, busy, addr_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got start/mvalid/busy/err=%b expected 0000",
                     {bif.ntt_start, bif.m_valid, busy, addr_err});
        end
        vectors++;
        if (bif.m_data !== '0 || bif.ntt_data_in_0 !== '0 || bif.ntt_data_in_1 !== '0) begin
            errors++;
            $display("FAIL reset_data: got m_data=%h in0=%h in1=%h expected 0",
                     bif.m_data, bif.ntt_data_in_0, bif.ntt_data_in_1);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (bif.s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got s_ready=%b busy=%b expected 1 0", bif.s_ready, busy);
        end
    endtask

    task automatic test_load(input logic [LOGQ-1:0] base);
        for (int i = 0; i < N; i++) begin
            din_m[i] = base + LOGQ'(i);
            bif.s_valid = 1'b1;
            bif.s_data  = din_m[i];
            vectors++;
            if (bif.s_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready beat %0d: got %b expected 1", i, bif.s_ready);
            end
            step();
            if (i == 0) begin
                vectors++;
                if (addr_err !== 1'b0) begin
                    errors++;
                    $display("FAIL load_clears_err: got %b expected 0", addr_err);
                end
            end
        end
        bif.s_valid = 1'b0;
        vectors++;
        if (bif.s_ready !== 1'b0 || bif.ntt_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_to_run: got s_ready=%b start=%b busy=%b expected 0 1 1",
                     bif.s_ready, bif.ntt_start, busy);
        end
    endtask

    task automatic test_read();
        int ras [4] = '{3, 0, 7, 5};
        for (int k = 0; k < 4; k++) begin
            bif.ntt_read_address = 10'(ras[k]);
            repeat (DELAY_BRAM) step();
            vectors++;
            if (bif.ntt_data_in_0 !== din_m[ras[k]] || bif.ntt_data_in_1 !== din_m[ras[k]+H]) begin
                errors++;
                $display("FAIL read ra=%0d: got %h/%h expected %h/%h", ras[k],
                         bif.ntt_data_in_0, bif.ntt_data_in_1, din_m[ras[k]], din_m[ras[k]+H]);
            end
        end
    endtask

    task automatic test_addr_err();
        bif.ntt_read_address = 10'd8;
        step();
        bif.ntt_read_address = 10'd0;
        vectors++;
        if (addr_err !== CHK) begin
            errors++;
            $display("FAIL addr_err_set: got %b expected %b", addr_err, CHK);
        end
        step(); step();
        vectors++;
        if (addr_err !== CHK) begin
            errors++;
            $display("FAIL addr_err_sticky: got %b expected %b", addr_err, CHK);
        end
    endtask

    task automatic test_write_finish(input logic [LOGQ-1:0] base, input int fwa,
                                     input logic [LOGQ-1:0] f0, input logic [LOGQ-1:0] f1);
        for (int wa = 0; wa < H; wa++) begin
            bif.ntt_wea = 1'b1;
            bif.ntt_write_address = 10'(wa);
            bif.ntt_data_out_0 = base + LOGQ'(wa);
            bif.ntt_data_out_1 = base + 64'h80 + LOGQ'(wa);
            dout_m[wa]   = bif.ntt_data_out_0;
            dout_m[wa+H] = bif.ntt_data_out_1;
            step();
        end
        bif.ntt_write_address = 10'(fwa);
        bif.ntt_data_out_0 = f0;
        bif.ntt_data_out_1 = f1;
        bif.ntt_finish = 1'b1;
        dout_m[fwa]   = f0;
        dout_m[fwa+H] = f1;
        step();
        bif.ntt_wea = 1'b0;
        bif.ntt_finish = 1'b0;
        vectors++;
        if (bif.ntt_start !== 1'b0 || busy !== 1'b1 || bif.m_valid !== 1'b0 || bif.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL finish: got start=%b busy=%b m_valid=%b s_ready=%b expected 0 1 0 0",
                     bif.ntt_start, busy, bif.m_valid, bif.s_ready);
        end
        for (int i = 0; i < N; i++) exp_q.push_back(dout_m[i]);
    endtask

    task automatic test_drain(input bit toggle);
        int cyc = 0;
        int first = -1;
        int beat = 0;
        bit stall = 1'b0;
        logic [LOGQ-1:0] held = '0;
        logic [LOGQ-1:0] exp;
        while (exp_q.size() > 0 && cyc < 200) begin
            bif.m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (stall) begin
                vectors++;
                if (bif.m_valid !== 1'b1 || bif.m_data !== held) begin
                    errors++;
                    $display("FAIL stall_hold cyc %0d: got v=%b d=%h expected 1 %h",
                             cyc, bif.m_valid, bif.m_data, held);
                end
            end
            if (bif.m_valid === 1'b1 && first < 0) first = cyc;
            if (bif.m_valid === 1'b1 && bif.m_ready === 1'b1) begin
                exp = exp_q.pop_front();
                vectors++;
                if (bif.m_data !== exp) begin
                    errors++;
                    $display("FAIL drain beat %0d: got %h expected %h", beat, bif.m_data, exp);
                end
                beat++;
            end
            stall = (bif.m_valid === 1'b1) && !bif.m_ready;
            held  = bif.m_data;
            step();
            cyc++;
        end
        bif.m_ready = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats expected %0d", beat, beat + exp_q.size());
            exp_q.delete();
        end
        vectors++;
        if (first != 2) begin
            errors++;
            $display("FAIL drain_latency: got %0d cycles expected 2", first);
        end
        if (!toggle) begin
            vectors++;
            if (cyc != N + 2) begin
                errors++;
                $display("FAIL drain_throughput: got %0d cycles expected %0d", cyc, N + 2);
            end
        end
        vectors++;
        if (bif.m_valid !== 1'b0 || busy !== 1'b0 || bif.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_end: got m_valid=%b busy=%b s_ready=%b expected 0 0 1",
                     bif.m_valid, busy, bif.s_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        test_load(64'd200);
        test_read();
        rst = 1'b1;
        step();
        vectors++;
        if (bif.ntt_start !== 1'b0 || bif.s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset: got start=%b s_ready=%b busy=%b expected 0 1 0",
                     bif.ntt_start, bif.s_ready, busy);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        test_load(64'h5000);
        test_read();
        test_write_finish(64'h9000, 2, 64'hC0DE, 64'hBEEF);
        test_drain(1'b0);
    endtask

    initial begin
        test_reset();
        test_load(64'd1);
        test_read();
        test_addr_err();
        test_write_finish(64'h100, 5, 64'hAA, 64'hBB);
        test_drain(1'b1);
        vectors++;
        if (addr_err !== CHK) begin
            errors++;
            $display("FAIL addr_err_after_drain: got %b expected %b", addr_err, CHK);
        end
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
